// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf receive path: default packet geometry,
// field-offset helpers, credit counter width and the credit arbiter states.
package leaf_pkg;

  // Default packet geometry of the BFT leaf interface.
  localparam int LEAF_PACKET_BITS  = 49;
  localparam int LEAF_PAYLOAD_BITS = 32;
  localparam int LEAF_ADDR_BITS    = 7;
  localparam int LEAF_PORT_BITS    = 4;

  // Width of the per-channel pending-credit counter (saturating).
  localparam int PEND_BITS = 4;

  // Credit arbiter states.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // The valid flag is the packet MSB.
  function automatic int valid_bit(input int packet_bits);
    return packet_bits - 1;
  endfunction

  // The port field sits directly above the address field, which sits
  // directly above the payload.
  function automatic int port_lsb(input int payload_bits, input int addr_bits);
    return payload_bits + addr_bits;
  endfunction

endpackage

// File: rtl/leaf_rx_fifo.sv
// Single-channel first-word-fall-through FIFO. Storage is an array written
// on push; the head word is kept in an output register so the output never
// depends combinationally on the push inputs and holds its last value when
// the FIFO goes empty. A push into a full FIFO is accepted only if a pop
// happens in the same cycle.
module leaf_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_inc;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] dout_reg;
  logic [WIDTH-1:0] dout_next;
  logic             push_ok;
  logic             pop_ok;

  assign valid      = (count_reg != '0);
  assign full       = (count_reg == (AW+1)'(DEPTH));
  assign count      = count_reg;
  assign dout       = dout_reg;
  assign pop_ok     = pop && valid;
  assign push_ok    = push && (!full || pop_ok);
  assign rd_ptr_inc = rd_ptr_reg + AW'(1);
  assign count_next = count_reg + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};

  // Next head word: after a pop the head moves to rd_ptr+1, which is the
  // incoming word itself when only one word was stored.
  always_comb begin
    dout_next = dout_reg;
    if (pop_ok) begin
      if (count_reg == (AW+1)'(1)) begin
        if (push_ok) dout_next = push_data;
      end else begin
        dout_next = mem[rd_ptr_inc];
      end
    end else if (!valid && push_ok) begin
      dout_next = push_data;
    end
  end

  // Storage write port; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_inc;
      count_reg <= count_next;
      dout_reg  <= dout_next;
    end
  end

endmodule

// File: rtl/leaf_rx_demux.sv
// Receive side of a page's leaf interface: decodes incoming BFT packets by
// port, steers payloads into per-channel FIFOs exposed as valid/ready
// streams, counts consumed words and issues freespace credits one at a time
// through a two-state arbiter (lowest channel first).
module leaf_rx_demux
  import leaf_pkg::*;
#(
  parameter int PACKET_BITS           = LEAF_PACKET_BITS,
  parameter int PAYLOAD_BITS          = LEAF_PAYLOAD_BITS,
  parameter int NUM_ADDR_BITS         = LEAF_ADDR_BITS,
  parameter int NUM_PORT_BITS         = LEAF_PORT_BITS,
  parameter int NUM_CH                = 4,
  parameter int PORT_BASE             = 2,
  parameter int FIFO_DEPTH            = 128,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                             clk,
  input  logic                             ap_rst_n,
  input  logic [PACKET_BITS-1:0]           din_leaf_bft2interface,
  output logic [NUM_CH*PAYLOAD_BITS-1:0]   m_tdata,
  output logic [NUM_CH-1:0]                m_tvalid,
  input  logic [NUM_CH-1:0]                m_tready,
  output logic                             credit_vld,
  output logic [NUM_PORT_BITS-1:0]         credit_ch,
  input  logic                             credit_rdy,
  output logic [NUM_CH-1:0]                err_overflow,
  output logic                             err_bad_port
);

  localparam int VALID_BIT = valid_bit(PACKET_BITS);
  localparam int PORT_LSB  = port_lsb(PAYLOAD_BITS, NUM_ADDR_BITS);
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int CONS_W    = $clog2(FREESPACE_UPDATE_SIZE + 1);
  localparam int PW        = NUM_PORT_BITS + 1;

  localparam logic [PW-1:0]        BASE_EXT  = PW'(PORT_BASE);
  localparam logic [PW-1:0]        LIMIT_EXT = PW'(PORT_BASE + NUM_CH);
  localparam logic [CONS_W-1:0]    CONS_LAST = CONS_W'(FREESPACE_UPDATE_SIZE - 1);
  localparam logic [PEND_BITS-1:0] PEND_MAX  = '1;

  // Packet decode. The port is widened by one bit so the range test and
  // the subtraction cannot wrap.
  logic                    pkt_valid;
  logic [PW-1:0]           port_ext;
  logic [PW-1:0]           ch_off;
  logic                    in_range;
  logic [PAYLOAD_BITS-1:0] payload;
  logic                    unused_ok;

  assign pkt_valid = din_leaf_bft2interface[VALID_BIT];
  assign port_ext  = {1'b0, din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS]};
  assign in_range  = (port_ext >= BASE_EXT) && (port_ext < LIMIT_EXT);
  assign ch_off    = port_ext - BASE_EXT;
  assign payload   = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
  // Address and spare header bits are carried but not interpreted here.
  assign unused_ok = ^din_leaf_bft2interface;

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] pend_inc;
  logic [NUM_CH-1:0] pend_dec;
  logic [NUM_CH-1:0] pend_nz;
  logic [NUM_CH-1:0] ovf_set;

  arb_state_e               state_reg, state_next;
  logic [CH_W-1:0]          sel_reg, sel_next;
  logic [CH_W-1:0]          pick;
  logic [NUM_PORT_BITS-1:0] credit_ch_reg, credit_ch_next;
  logic [NUM_CH-1:0]        err_overflow_reg;
  logic                     err_bad_port_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CONS_W-1:0]    cons_reg;
      logic [PEND_BITS-1:0] pend_reg;
      logic [CNT_W-1:0]     count_unused;

      assign push[gi] = pkt_valid && in_range && (ch_off == PW'(gi));
      assign pop[gi]  = m_tvalid[gi] && m_tready[gi];

      leaf_rx_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (ap_rst_n),
        .push      (push[gi]),
        .push_data (payload),
        .pop       (pop[gi]),
        .dout      (m_tdata[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
        .valid     (m_tvalid[gi]),
        .count     (count_unused),
        .full      (fifo_full[gi])
      );

      assign pend_inc[gi] = pop[gi] && (cons_reg == CONS_LAST);
      assign pend_dec[gi] = (state_reg == BUSY) && credit_rdy && (sel_reg == CH_W'(gi));
      assign pend_nz[gi]  = (pend_reg != '0);
      // Drop on a full FIFO without a same-cycle pop, or a credit lost to
      // pend saturation.
      assign ovf_set[gi]  = (push[gi] && fifo_full[gi] && !pop[gi]) ||
                            (pend_inc[gi] && !pend_dec[gi] && (pend_reg == PEND_MAX));

      // Count pops; every FREESPACE_UPDATE_SIZE pops yields one credit.
      always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          cons_reg <= '0;
        end else if (pop[gi]) begin
          cons_reg <= pend_inc[gi] ? '0 : cons_reg + CONS_W'(1);
        end
      end

      // Pending credits: saturating up, down when the arbiter is accepted.
      always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          pend_reg <= '0;
        end else if (pend_inc[gi] && !pend_dec[gi]) begin
          if (pend_reg != PEND_MAX) pend_reg <= pend_reg + PEND_BITS'(1);
        end else if (!pend_inc[gi] && pend_dec[gi]) begin
          pend_reg <= pend_reg - PEND_BITS'(1);
        end
      end
    end
  endgenerate

  // Lowest-index channel with a pending credit.
  always_comb begin
    pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_nz[i]) pick = CH_W'(i);
    end
  end

  // Arbiter next state: latch a channel in IDLE, hold it in BUSY until accepted.
  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    credit_ch_next = credit_ch_reg;
    case (state_reg)
      IDLE: begin
        if (pend_nz != '0) begin
          state_next     = BUSY;
          sel_next       = pick;
          credit_ch_next = NUM_PORT_BITS'(PORT_BASE) + NUM_PORT_BITS'(pick);
        end
      end
      BUSY: begin
        if (credit_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      credit_ch_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      credit_ch_reg <= credit_ch_next;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_overflow_reg <= '0;
      err_bad_port_reg <= 1'b0;
    end else begin
      err_overflow_reg <= err_overflow_reg | ovf_set;
      if (pkt_valid && !in_range) err_bad_port_reg <= 1'b1;
    end
  end

  assign credit_vld   = (state_reg == BUSY);
  assign credit_ch    = credit_ch_reg;
  assign err_overflow = err_overflow_reg;
  assign err_bad_port = err_bad_port_reg;

endmodule

// File: tb/tb_leaf_rx_demux.sv
// Directed bench for leaf_rx_demux with default parameters (4 channels,
// port base 2, depth 128, credit every 64 pops).
module tb_leaf_rx_demux;

  logic         clk = 1'b0;
  logic         ap_rst_n;
  logic [48:0]  din;
  logic [127:0] m_tdata;
  logic [3:0]   m_tvalid;
  logic [3:0]   m_tready;
  logic         credit_vld;
  logic [3:0]   credit_ch;
  logic         credit_rdy;
  logic [3:0]   err_overflow;
  logic         err_bad_port;

  int n_assert = 0;
  int n_fail   = 0;
  int ncred    = 0;

  always #5 clk = ~clk;

  leaf_rx_demux dut (
    .clk                    (clk),
    .ap_rst_n               (ap_rst_n),
    .din_leaf_bft2interface (din),
    .m_tdata                (m_tdata),
    .m_tvalid               (m_tvalid),
    .m_tready               (m_tready),
    .credit_vld             (credit_vld),
    .credit_ch              (credit_ch),
    .credit_rdy             (credit_rdy),
    .err_overflow           (err_overflow),
    .err_bad_port           (err_bad_port)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Packet: valid at bit 48, port at [42:39], address zero, payload [31:0].
  function automatic logic [48:0] pkt(input logic [3:0] port, input logic [31:0] data);
    logic [48:0] p;
    p        = '0;
    p[48]    = 1'b1;
    p[42:39] = port;
    p[31:0]  = data;
    return p;
  endfunction

  function automatic logic [31:0] lane(input int c);
    return m_tdata[c*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle and record any credit seen (each lasts one sample
  // while credit_rdy is high).
  task automatic tick_count(input logic [3:0] exp_ch);
    tick();
    if (credit_vld) begin
      ncred++;
      chk("credit_ch", credit_ch, exp_ch);
    end
  endtask

  task automatic do_reset();
    ap_rst_n   = 1'b0;
    din        = '0;
    m_tready   = '0;
    credit_rdy = 1'b0;
    tick();
    tick();
    ap_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;

    // 1: reset state, single packet latency.
    $display("step: reset and single packet");
    do_reset();
    chk("rst_tvalid", m_tvalid, 4'h0);
    chk("rst_tdata", m_tdata, 128'h0);
    chk("rst_credit_vld", credit_vld, 1'b0);
    chk("rst_credit_ch", credit_ch, 4'h0);
    chk("rst_err_ovf", err_overflow, 4'h0);
    chk("rst_err_bad", err_bad_port, 1'b0);
    m_tready = 4'hF;
    din = pkt(4'd2, 32'hDEADBEEF);
    tick();
    din = '0;
    chk("single_tvalid", m_tvalid, 4'b0001);
    chk("single_tdata", lane(0), 32'hDEADBEEF);
    tick();
    chk("single_popped", m_tvalid, 4'b0000);
    chk("single_hold", lane(0), 32'hDEADBEEF);

    // 2: fill channel 1, overflow on the 129th, drain in order.
    $display("step: channel 1 overflow and drain");
    do_reset();
    m_tready   = 4'b1101;
    credit_rdy = 1'b1;
    for (int i = 0; i < 128; i++) begin
      din = pkt(4'd3, i);
      tick();
    end
    chk("full_no_err", err_overflow, 4'h0);
    chk("full_tvalid", m_tvalid, 4'b0010);
    din = pkt(4'd3, 32'hBAD0BAD0);
    tick();
    din = '0;
    chk("ovf_err", err_overflow, 4'b0010);
    m_tready = 4'hF;
    for (int i = 0; i < 128; i++) begin
      chk($sformatf("drain1_%0d", i), {m_tvalid[1], lane(1)}, {1'b1, 32'(i)});
      tick();
    end
    chk("drain1_empty", m_tvalid, 4'h0);
    chk("drain1_hold", lane(1), 32'd127);
    chk("ovf_sticky", err_overflow, 4'b0010);

    // 3: bad ports (boundary and far), good traffic continues.
    $display("step: bad port handling");
    do_reset();
    m_tready = 4'hF;
    din = pkt(4'd9, 32'h11111111);
    tick();
    din = '0;
    chk("bad9_tvalid", m_tvalid, 4'h0);
    chk("bad9_err", err_bad_port, 1'b1);
    din = pkt(4'd6, 32'h66666666);
    tick();
    din = pkt(4'd1, 32'h11110001);
    chk("bad6_tvalid", m_tvalid, 4'h0);
    tick();
    din = pkt(4'd2, 32'h12345678);
    chk("bad1_tvalid", m_tvalid, 4'h0);
    tick();
    din = pkt(4'd5, 32'hCAFE0005);
    chk("good2_tvalid", m_tvalid, 4'b0001);
    chk("good2_tdata", lane(0), 32'h12345678);
    tick();
    din = '0;
    chk("good5_tvalid", m_tvalid, 4'b1000);
    chk("good5_tdata", lane(3), 32'hCAFE0005);
    chk("bad_no_ovf", err_overflow, 4'h0);
    chk("bad_sticky", err_bad_port, 1'b1);

    // 4: one credit per 64 pops on channel 0.
    $display("step: credit after 64 pops");
    do_reset();
    m_tready   = 4'hF;
    credit_rdy = 1'b1;
    ncred      = 0;
    for (int i = 0; i < 64; i++) begin
      din = pkt(4'd2, i);
      tick_count(4'd2);
    end
    din = '0;
    for (int i = 0; i < 8; i++) tick_count(4'd2);
    chk("credits_64", ncred, 1);
    for (int i = 0; i < 63; i++) begin
      din = pkt(4'd2, i);
      tick_count(4'd2);
    end
    din = '0;
    for (int i = 0; i < 8; i++) tick_count(4'd2);
    chk("credits_127", ncred, 1);
    din = pkt(4'd2, 32'h0);
    tick_count(4'd2);
    din = '0;
    for (int i = 0; i < 8; i++) tick_count(4'd2);
    chk("credits_128", ncred, 2);

    // 5: channels 0 and 2 credit together; arbitration and hold.
    $display("step: simultaneous credits on channels 0 and 2");
    do_reset();
    for (int i = 0; i < 64; i++) begin
      din = pkt(4'd2, i);
      tick();
      din = pkt(4'd4, 32'h100 + i);
      tick();
    end
    din = '0;
    chk("dual_fill", m_tvalid, 4'b0101);
    m_tready = 4'b0101;
    repeat (64) tick();
    chk("dual_drained", m_tvalid, 4'h0);
    chk("dual_no_credit_yet", credit_vld, 1'b0);
    waited = 0;
    while (!credit_vld && waited < 10) begin
      tick();
      waited++;
    end
    chk("dual_credit_seen", credit_vld, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold_ch_%0d", k), {credit_vld, credit_ch}, {1'b1, 4'd2});
      tick();
    end
    credit_rdy = 1'b1;
    tick();
    chk("gap_after_first", credit_vld, 1'b0);
    tick();
    chk("second_credit", {credit_vld, credit_ch}, {1'b1, 4'd4});
    tick();
    chk("after_second", credit_vld, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("no_extra_%0d", k), credit_vld, 1'b0);
    end

    // 6: full FIFO with simultaneous push and pop.
    $display("step: push and pop on full fifo");
    do_reset();
    for (int i = 0; i < 128; i++) begin
      din = pkt(4'd2, i);
      tick();
    end
    chk("full0_tvalid", m_tvalid, 4'b0001);
    din = pkt(4'd2, 32'h55AA55AA);
    m_tready = 4'b0001;
    tick();
    din = '0;
    chk("pushpop_no_err", err_overflow, 4'h0);
    for (int i = 1; i < 128; i++) begin
      chk($sformatf("drain0_%0d", i), {m_tvalid[0], lane(0)}, {1'b1, 32'(i)});
      tick();
    end
    chk("drain0_last", {m_tvalid[0], lane(0)}, {1'b1, 32'h55AA55AA});
    tick();
    chk("drain0_empty", m_tvalid, 4'h0);
    chk("pushpop_err_end", err_overflow, 4'h0);

    // 7: asynchronous reset mid-operation discards contents.
    $display("step: asynchronous reset mid-operation");
    m_tready = 4'h0;
    din = pkt(4'd5, 32'h00000001);
    tick();
    din = '0;
    chk("pre_rst_tvalid", m_tvalid, 4'b1000);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", m_tvalid, 4'h0);
    chk("async_rst_tdata", m_tdata, 128'h0);
    tick();
    ap_rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_tvalid", m_tvalid, 4'h0);
    chk("post_rst_credit", credit_vld, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/leaf_rx_demux.md
Name: leaf_rx_demux

Overview:
- Parametrised receive side of a page's leaf interface.
- Accepts packets from the BFT leaf and steers each packet's payload by its port field into one of NUM_CH per-channel FIFOs.
- Each FIFO presents an AXI-stream-style TDATA/TVALID/TREADY channel to the user kernel.
- Counts words consumed per channel and emits freespace credit requests, arbitrated onto one credit port, so the upstream sender can be refilled.
- Generalises the fixed 4-input, 32-bit page input path to N channels, configurable depth and credit granularity, with drop and error reporting.

Parameters:
- PACKET_BITS, 49, total packet width; bit PACKET_BITS-1 is the packet valid flag.
- PAYLOAD_BITS, 32, payload width, bits [PAYLOAD_BITS-1:0].
- NUM_ADDR_BITS, 7, address field directly above the payload; ignored by this block.
- NUM_PORT_BITS, 4, port field directly above the address field.
- NUM_CH, 4, number of user input channels (1..15).
- PORT_BASE, 2, port field value mapped to channel 0.
- FIFO_DEPTH, 128, words per channel FIFO; power of two, at least 2.
- FREESPACE_UPDATE_SIZE, 64, pops per credit; must be no greater than FIFO_DEPTH.

Ports:
- clk  in  1  single clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- din_leaf_bft2interface  in  PACKET_BITS  incoming packet; valid flag in the MSB.
- m_tdata  out  NUM_CH*PAYLOAD_BITS  per-channel data; channel i occupies slice i.
- m_tvalid  out  NUM_CH  per-channel valid.
- m_tready  in  NUM_CH  per-channel ready from the user.
- credit_vld  out  1  credit request valid.
- credit_ch  out  NUM_PORT_BITS  port number (PORT_BASE + channel) being credited.
- credit_rdy  in  1  credit accepted by the packet encoder.
- err_overflow  out  NUM_CH  sticky: a packet was dropped because the channel FIFO was full.
- err_bad_port  out  1  sticky: a valid packet arrived with an unmapped port.

Behaviour:
- Reset (asynchronous assert, synchronous release): all FIFOs empty; m_tvalid=0; m_tdata=0; credit_vld=0; credit_ch=0; all counters=0; err_overflow=0; err_bad_port=0.
- Decode: a packet is valid when its MSB is 1. ch = port - PORT_BASE.
  - Port outside [PORT_BASE, PORT_BASE+NUM_CH-1]: drop the packet and set err_bad_port.
- Write: a valid packet for ch is written at the next rising edge when count[ch] < FIFO_DEPTH, or when the FIFO is full and a pop occurs on ch in the same cycle.
  - Otherwise drop the packet and set err_overflow[ch]. No backpressure toward the BFT.
- Latency: a packet sampled at edge t appears on m_tdata[ch] with m_tvalid[ch]=1 after edge t (first-word fall-through from registered storage). There is no combinational path from input to output.
- Pop: occurs when m_tvalid[ch] && m_tready[ch]. m_tdata is held stable while m_tvalid=1 and m_tready=0.
- Empty: m_tvalid=0 and m_tdata holds its last value.
- Pointers: the FIFO_DEPTH pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits wide.
- Consumption counter cons[ch]: increments on each pop. On reaching FREESPACE_UPDATE_SIZE it wraps to 0 and increments pend[ch].
  - pend[ch] is a 4-bit saturating counter. Saturation loses credits and sets err_overflow[ch].
- Credit arbiter, two states:
  - IDLE: if any pend is nonzero, select the lowest-index channel c with pend[c] nonzero. Drive credit_ch = PORT_BASE + c and credit_vld = 1, and go to BUSY.
  - BUSY: hold credit_ch and credit_vld until credit_rdy=1. At that edge decrement pend[c], deassert credit_vld, and return to IDLE.
  - Consequence: at most one credit every 2 cycles.
  - A pend[c] increment and decrement in the same cycle leave pend[c] unchanged.
- Errors: sticky; cleared only by reset.
- Reset mid-operation: in-flight FIFO contents and pending credits are discarded. No credit is emitted for them.

Decomposition:
- Package leaf_pkg: field offset localparams (valid bit, port field LSB/MSB, address width), the credit pend width, and the arbiter state enum {IDLE, BUSY}.
- Sub-module leaf_rx_fifo: single-channel, parametrised by width and depth. Ports: push, push_data, pop, dout, valid, count, full. Instantiated NUM_CH times in a generate loop.
- The top level holds the decode, the consumption counters and the credit arbiter.

Test Plan:
- Reset then single packet, port=2, payload 0xDEADBEEF, m_tready=1 -> m_tvalid[0]=1 exactly one cycle after the input edge with m_tdata[31:0]=0xDEADBEEF; no other channel goes valid.
- Port=3, 128 back-to-back packets then a 129th, m_tready[1]=0 -> 128 words held, the 129th dropped, err_overflow[1]=1; releasing ready drains payloads in order 0..127.
- Port=9 packet with NUM_CH=4 -> no channel goes valid and err_bad_port=1; port=2 traffic continues unaffected.
- 64 pops on channel 0 with credit_rdy=1 -> exactly one credit with credit_vld=1 and credit_ch=2; cons[0]=0 afterwards.
- Channels 0 and 2 both reach 64 pops in the same cycle, credit_rdy held 0 for 5 cycles then 1 -> credit_ch=2 is held stable first, then credit_ch=4 follows; each credit is issued exactly once.
- Full FIFO with simultaneous push and pop on the same channel -> the push is accepted, count stays 128, and err_overflow is not set.
